dcm_lock_sequencer: RTL

Sequences the FPGA clock manager (DCM) after configuration and after lock loss.
- Pulses the DCM reset for a fixed hold time.
- Waits for LOCKED with a timeout and retries, up to a limit.
- Requires LOCKED to stay stable before releasing the downstream system reset.
- Sits between the board reset and the DCM wrapper. Its sys_reset drives every register in the derived clock domains.

---
 rtl/dcm_seq_pkg.sv | 15 +
 rtl/dcm_lock_sequencer_bit_sync2.sv | 26 ++
 rtl/dcm_lock_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dcm_seq_pkg.sv
// Shared types and constants for the DCM lock sequencer.
// State encoding and the retry counter width.
package dcm_seq_pkg;

  localparam int RetryW = 4;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

endpackage

// File: rtl/dcm_lock_sequencer_bit_sync2.sv
// Two-flop synchronizer for a single asynchronous status bit.
// Synchronous active-high reset clears both stages to 0.
module bit_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // shift the async input through two flops
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/dcm_lock_sequencer.sv
// DCM bring-up sequencer: reset pulse, lock wait with retries,
// lock settle, and downstream reset release.
module dcm_lock_sequencer
  import dcm_seq_pkg::*;
#(
  parameter int CntSize       = 16,
  parameter int RstHoldCycles = 8,
  parameter int LockTimeout   = 50000,
  parameter int StableCycles  = 16,
  parameter int MaxRetries    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dcm_locked,
  input  logic              force_relock,
  output logic              dcm_reset,
  output logic              sys_reset,
  output logic              ready,
  output logic              fail,
  output logic              lock_lost,
  output logic [RetryW-1:0] retry_count
);

  localparam logic [CntSize-1:0] HoldLast =
    CntSize'(RstHoldCycles - 1);
  localparam logic [CntSize-1:0] ToLast =
    CntSize'(LockTimeout - 1);
  localparam logic [CntSize-1:0] StableLast =
    CntSize'(StableCycles - 1);
  localparam logic [RetryW-1:0] RetryMax =
    RetryW'(MaxRetries);

  logic locked_s;

  bit_sync2 u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (dcm_locked),
    .q_o   (locked_s)
  );

  state_t              state_q, state_d;
  logic [CntSize-1:0]  cnt_q, cnt_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic                lost_d;
  logic                retry_ev;
  logic                dcm_reset_q;
  logic                sys_reset_q;
  logic                ready_q;
  logic                fail_q;
  logic                lost_q;

  // next state: relock request wins over every lock event
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    lost_d   = 1'b0;
    retry_ev = 1'b0;
    if (force_relock && state_q != HOLD) begin
      state_d = HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (cnt_q == HoldLast) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntSize'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == ToLast) begin
            retry_ev = 1'b1;
          end else begin
            cnt_d = cnt_q + CntSize'(1);
          end
        end
        SETTLE: begin
          if (!locked_s) begin
            retry_ev = 1'b1;
          end else if (cnt_q == StableLast) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntSize'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            lost_d  = 1'b1;
            retry_d = '0;
            state_d = HOLD;
            cnt_d   = '0;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      endcase
      if (retry_ev) begin
        cnt_d = '0;
        if (retry_q == RetryMax) begin
          state_d = FAIL;
        end else begin
          retry_d = retry_q + RetryW'(1);
          state_d = HOLD;
        end
      end
    end
  end

  // state, counter and outputs all move on the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      retry_q     <= '0;
      dcm_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      dcm_reset_q <= (state_d == HOLD) || (state_d == FAIL);
      sys_reset_q <= (state_d != RUN);
      ready_q     <= (state_d == RUN);
      fail_q      <= (state_d == FAIL);
      lost_q      <= lost_d;
    end
  end

  assign dcm_reset   = dcm_reset_q;
  assign sys_reset   = sys_reset_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign lock_lost   = lost_q;
  assign retry_count = retry_q;

endmodule
